// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch side of the core.
//   FQ_DEPTH   default fetch queue depth
//   PC_RESET   PC the fetch unit starts from after reset
//   INSTR_W    instruction word width
//   fq_entry_t one fetch queue entry, {pc, instr}
//   is_pow2    helper used to validate queue depth parameters
package cpu_pkg;

    localparam int          FQ_DEPTH = 4;
    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int          INSTR_W  = 32;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fq_ring.sv
// fq_ring: storage array for the fetch queue.
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset, clears every entry to 0
//   we_i     in   write enable
//   waddr_i  in   write index
//   wdata_i  in   entry to write
//   raddr_i  in   read index
//   rdata_o  out  entry at raddr_i, combinational from the registers
// Pointer, occupancy and handshake logic live in fetch_queue.
module fq_ring
    import cpu_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  fq_entry_t     wdata_i,
    input  logic [AW-1:0] raddr_i,
    output fq_entry_t     rdata_o
);

    fq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // No write-to-read bypass: a word written at an edge is visible
    // on the read port only after that edge.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling buffer between instruction fetch and decode.
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset, empties the queue
//   if_instr  in   instruction word presented by fetch
//   if_pc     in   PC of if_instr
//   if_valid  in   fetch word is meaningful this cycle
//   if_enable out  fetch advances its PC at the next edge
//   flush     in   jump redirect; discards all queued words at the edge
//   id_valid  out  head entry is valid
//   id_ready  in   decode consumes the head entry at the next edge
//   id_instr  out  head instruction
//   id_pc     out  head PC
//   count     out  occupied entries, 0..DEPTH
//
// Handshakes:
//   fetch side : a word transfers at an edge when if_valid && if_enable
//                && !flush. if_enable depends only on registered occupancy
//                and flush, never on id_ready, so a pop in the same cycle
//                does not open a slot in a full queue.
//   decode side: the head transfers at an edge when id_valid && id_ready
//                && !flush. id_valid is !empty; id_instr/id_pc show the
//                entry at the read pointer and are stale while empty.
//   flush wins over both transfers and empties the queue at the edge.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [31:0]        if_pc,
    input  logic               if_valid,
    output logic               if_enable,
    input  logic               flush,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc,
    output logic [AW:0]        count
);

    if (!is_pow2(DEPTH) || DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two in 2..16");
    end

    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    fq_entry_t wr_entry;
    fq_entry_t rd_entry;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);

    // Full blocks push even when a pop happens in the same cycle.
    assign push = if_valid && !full && !flush;
    assign pop  = id_valid && id_ready && !flush;

    // During flush fetch must load the jump target even if the queue is full.
    assign if_enable = !full || flush;
    assign id_valid  = !empty;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + PTR_ONE;
            end
            if (pop) begin
                rp_d = rp_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign wr_entry.pc    = if_pc;
    assign wr_entry.instr = if_instr;

    fq_ring #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .we_i    (push),
        .waddr_i (wp_q),
        .wdata_i (wr_entry),
        .raddr_i (rp_q),
        .rdata_o (rd_entry)
    );

    assign id_instr = rd_entry.instr;
    assign id_pc    = rd_entry.pc;
    assign count    = cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH = FQ_DEPTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               reset;
    logic [INSTR_W-1:0] if_instr;
    logic [31:0]        if_pc;
    logic               if_valid;
    logic               if_enable;
    logic               flush;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [31:0]        id_pc;
    logic [AW:0]        count;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .if_valid  (if_valid),
        .if_enable (if_enable),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .count     (count)
    );

    // ---------------- scoreboard / fetch model ----------------
    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic [31:0] jump_target;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle. Before the edge (at negedge) the scoreboard decides
    // from its own queue what the DUT must do; after the edge the fetch
    // model presents its next word.
    task automatic tick();
        bit          mfull;
        bit          exp_en;
        logic [63:0] head;
        @(negedge clk);
        if (reset) begin
            exp_q.delete();
            next_pc = PC_RESET;
        end else begin
            mfull  = (exp_q.size() == DEPTH);
            exp_en = !mfull || flush;
            checks++;
            if (if_enable !== exp_en) begin
                errors++;
                $display("FAIL sb_if_enable: got %b want %b", if_enable, exp_en);
            end
            checks++;
            if (id_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL sb_id_valid: got %b want %b", id_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0 && id_ready && !flush) begin
                head = exp_q.pop_front();
                pops++;
                checks++;
                if ({id_pc, id_instr} !== head) begin
                    errors++;
                    $display("FAIL sb_head: got pc=%h instr=%h want pc=%h instr=%h",
                             id_pc, id_instr, head[63:32], head[31:0]);
                end
            end
            if (if_valid && !mfull && !flush) exp_q.push_back({if_pc, if_instr});
            if (flush) exp_q.delete();
            next_pc = fetch_pc;
            if (exp_en && if_valid) next_pc = flush ? jump_target : fetch_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        fetch_pc = next_pc;
        if_pc    = fetch_pc;
        if_instr = instr_of(fetch_pc);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        if_valid = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if (if_enable !== 1'b1) begin errors++; $display("FAIL reset_if_enable: got %b want 1", if_enable); end
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        checks++;
        if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_instr: got %h want 0", id_instr); end
        checks++;
        if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
        checks++;
        if (count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        int pops_before;
        do_reset();
        id_ready = 1'b1;
        if_valid = 1'b1;
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_pre_valid: got %b want 0", id_valid); end
        tick();
        checks++;
        if (id_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid: got %b want 1", id_valid); end
        checks++;
        if (id_pc !== 32'h3000) begin errors++; $display("FAIL stream_first_pc: got %h want 00003000", id_pc); end
        pops_before = pops;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (count !== CW'(1)) begin errors++; $display("FAIL stream_count: got %0d want 1", count); end
        end
        checks++;
        if (pops - pops_before != 10) begin
            errors++;
            $display("FAIL stream_pops: got %0d want 10", pops - pops_before);
        end
        checks++;
        if (id_pc !== 32'h3028) begin errors++; $display("FAIL stream_last_pc: got %h want 00003028", id_pc); end
    endtask

    task automatic test_full_and_wrap();
        do_reset();
        id_ready = 1'b0;
        if_valid = 1'b1;
        repeat (DEPTH + 2) tick();
        checks++;
        if (count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d want %0d", count, DEPTH); end
        checks++;
        if (if_enable !== 1'b0) begin errors++; $display("FAIL full_if_enable: got %b want 0", if_enable); end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        checks++;
        if (count !== CW'(DEPTH - 1)) begin errors++; $display("FAIL one_pop_count: got %0d want %0d", count, DEPTH - 1); end
        checks++;
        if (if_enable !== 1'b1) begin errors++; $display("FAIL one_pop_if_enable: got %b want 1", if_enable); end
        tick();
        checks++;
        if (count !== CW'(DEPTH)) begin errors++; $display("FAIL refill_count: got %0d want %0d", count, DEPTH); end
        if_valid = 1'b0;
        id_ready = 1'b1;
        repeat (DEPTH) tick();
        checks++;
        if (count !== CW'(0) || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got count=%0d valid=%b want count=0 valid=0", count, id_valid);
        end
        for (int i = 0; i < 60; i++) begin
            id_ready = 1'($urandom_range(0, 1));
            if_valid = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (count !== CW'(exp_q.size())) begin
                errors++;
                $display("FAIL wrap_count: got %0d want %0d", count, exp_q.size());
            end
        end
    endtask

    task automatic test_empty_ready();
        do_reset();
        if_valid = 1'b0;
        id_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (count !== CW'(0) || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_ready: got count=%0d valid=%b want count=0 valid=0", count, id_valid);
        end
        if_valid = 1'b1;
        tick();
        if_valid = 1'b0;
        id_ready = 1'b0;
        checks++;
        if (count !== CW'(1)) begin errors++; $display("FAIL empty_then_push_count: got %0d want 1", count); end
        checks++;
        if (id_pc !== 32'h3000) begin errors++; $display("FAIL empty_then_push_pc: got %h want 00003000", id_pc); end
    endtask

    task automatic test_flush();
        do_reset();
        id_ready = 1'b0;
        if_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if (count !== CW'(3)) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        flush       = 1'b1;
        jump_target = 32'h3400;
        tick();
        flush = 1'b0;
        checks++;
        if (count !== CW'(0) || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: got count=%0d valid=%b want count=0 valid=0", count, id_valid);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h3400) begin
            errors++;
            $display("FAIL flush_target: got valid=%b pc=%h want valid=1 pc=00003400", id_valid, id_pc);
        end
        checks++;
        if (id_instr !== instr_of(32'h3400)) begin
            errors++;
            $display("FAIL flush_target_instr: got %h want %h", id_instr, instr_of(32'h3400));
        end
    endtask

    task automatic test_flush_full();
        do_reset();
        id_ready = 1'b0;
        if_valid = 1'b1;
        repeat (DEPTH) tick();
        checks++;
        if (if_enable !== 1'b0) begin errors++; $display("FAIL flush_full_pre_enable: got %b want 0", if_enable); end
        flush       = 1'b1;
        jump_target = 32'h3800;
        #1;
        checks++;
        if (if_enable !== 1'b1) begin errors++; $display("FAIL flush_full_enable: got %b want 1", if_enable); end
        tick();
        flush = 1'b0;
        checks++;
        if (count !== CW'(0)) begin errors++; $display("FAIL flush_full_count: got %0d want 0", count); end
        tick();
        checks++;
        if (id_pc !== 32'h3800) begin errors++; $display("FAIL flush_full_target: got %h want 00003800", id_pc); end
    endtask

    task automatic test_flush_ready();
        do_reset();
        id_ready = 1'b0;
        if_valid = 1'b1;
        repeat (2) tick();
        flush       = 1'b1;
        id_ready    = 1'b1;
        jump_target = 32'h3500;
        tick();
        flush    = 1'b0;
        id_ready = 1'b0;
        checks++;
        if (count !== CW'(0) || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got count=%0d valid=%b want count=0 valid=0", count, id_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        id_ready = 1'b0;
        if_valid = 1'b1;
        repeat (2) tick();
        checks++;
        if (count !== CW'(2)) begin errors++; $display("FAIL async_pre_count: got %0d want 2", count); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count !== CW'(0)) begin errors++; $display("FAIL async_count: got %0d want 0", count); end
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL async_id_valid: got %b want 0", id_valid); end
        checks++;
        if (id_pc !== 32'h0 || id_instr !== 32'h0) begin
            errors++;
            $display("FAIL async_id_data: got pc=%h instr=%h want 0", id_pc, id_instr);
        end
        checks++;
        if (if_enable !== 1'b1) begin errors++; $display("FAIL async_if_enable: got %b want 1", if_enable); end
        if_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset       = 1'b1;
        if_valid    = 1'b0;
        flush       = 1'b0;
        id_ready    = 1'b0;
        jump_target = 32'h0;
        fetch_pc    = PC_RESET;
        next_pc     = PC_RESET;
        if_pc       = fetch_pc;
        if_instr    = instr_of(fetch_pc);

        test_reset();
        test_stream();
        test_full_and_wrap();
        test_empty_ready();
        test_flush();
        test_flush_full();
        test_flush_ready();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
